// File: rtl/param_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : param_bus_mux
// Purpose  : Parameterised N-to-1 valid/ready bus multiplexer with a single
//            registered output stage. Source selection is either manual
//            (i_select code) or round-robin arbitration over the channels
//            that present valid data. Counts completed output handshakes.
// Ports    : clk           - single clock, rising edge
//            rstn          - synchronous active-low reset
//            i_mode        - 0 = manual select, 1 = round-robin
//            i_select      - manual code k (1..NUM_CH) selects channel k-1
//            i_in_data     - packed channel data, ch i at [i*DATA_W +: DATA_W]
//            i_in_valid    - per-channel valid
//            o_in_ready    - per-channel accept (combinational, one-hot/zero)
//            o_out_data    - registered selected word
//            o_out_valid   - output register holds an unconsumed word
//            i_out_ready   - downstream accepts o_out_data
//            o_out_ch      - 1-based source code of held word, 0 when empty
//            o_xfer_count  - completed output handshakes, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module param_bus_mux #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_mode,
  input  logic [SEL_W-1:0]         i_select,
  input  logic [NUM_CH*DATA_W-1:0] i_in_data,
  input  logic [NUM_CH-1:0]        i_in_valid,
  output logic [NUM_CH-1:0]        o_in_ready,
  output logic [DATA_W-1:0]        o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [SEL_W-1:0]         o_out_ch,
  output logic [15:0]              o_xfer_count
);

  // Output stage state encoding
  localparam logic [0:0] c_ST_EMPTY = 1'b0;
  localparam logic [0:0] c_ST_FULL  = 1'b1;

  localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] c_NUM_CH  = SEL_W'(NUM_CH);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [SEL_W-1:0]  r_last_grant;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [15:0]       r_xfer_count;

  logic [DATA_W-1:0] w_ch_data [NUM_CH];
  logic              w_man_hit;
  logic [SEL_W-1:0]  w_man_idx;
  logic              w_rr_hit;
  logic [SEL_W-1:0]  w_rr_idx;
  int                w_cand;
  logic              w_grant_hit;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [NUM_CH-1:0] w_grant_vec;
  logic              w_can_load;
  logic              w_xfer;
  logic              w_out_hs;
  logic [DATA_W-1:0] w_sel_data;

  // --------------------------------------------------------------------------
  // Unpack channel data into an array for indexed selection
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign w_ch_data[gi] = i_in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Manual grant: code 0 and codes above NUM_CH grant nothing
  // --------------------------------------------------------------------------
  assign w_man_hit = (i_select != '0) && (i_select <= c_NUM_CH);
  assign w_man_idx = i_select - SEL_W'(1);

  // --------------------------------------------------------------------------
  // Round-robin search starting at last_grant+1 with wrap. Offsets are
  // scanned from the farthest to the nearest so the nearest valid channel
  // is the last assignment and therefore wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_cand   = 0;
    for (int off = NUM_CH; off >= 1; off--) begin
      w_cand = int'(r_last_grant) + off;
      if (w_cand >= NUM_CH) begin
        w_cand = w_cand - NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if ((w_cand == i) && i_in_valid[i]) begin
          w_rr_hit = 1'b1;
          w_rr_idx = SEL_W'(i);
        end
      end
    end
  end

  assign w_grant_hit = i_mode ? w_rr_hit : w_man_hit;
  assign w_grant_idx = i_mode ? w_rr_idx : w_man_idx;

  always_comb begin
    w_grant_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_grant_vec[i] = w_grant_hit && (w_grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        w_sel_data = w_ch_data[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake qualification. The register can accept a new word when it is
  // empty or when the held word leaves in this same cycle. rstn gates the
  // ready so nothing is accepted while reset is asserted.
  // --------------------------------------------------------------------------
  assign w_can_load = (r_state == c_ST_EMPTY) || i_out_ready;
  assign o_in_ready = w_grant_vec & {NUM_CH{w_can_load & rstn}};
  assign w_xfer     = |(i_in_valid & o_in_ready);
  assign w_out_hs   = o_out_valid & i_out_ready;

  // --------------------------------------------------------------------------
  // Output stage FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output stage FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: begin
        if (w_xfer) begin
          w_state_nxt = c_ST_FULL;
        end
      end
      c_ST_FULL: begin
        if (w_xfer) begin
          w_state_nxt = c_ST_FULL;
        end else if (i_out_ready) begin
          w_state_nxt = c_ST_EMPTY;
        end
      end
      default: w_state_nxt = c_ST_EMPTY;
    endcase
  end

  // Output stage FSM: output logic
  always_comb begin
    o_out_valid = 1'b0;
    case (r_state)
      c_ST_FULL: o_out_valid = 1'b1;
      default:   o_out_valid = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Data path. A load takes priority over clearing, which is what gives
  // back-to-back words with no bubble when both happen together.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_data <= '0;
      r_out_ch   <= '0;
    end else if (w_xfer) begin
      r_out_data <= w_sel_data;
      r_out_ch   <= w_grant_idx + SEL_W'(1);
    end else if (w_out_hs) begin
      r_out_data <= '0;
      r_out_ch   <= '0;
    end
  end

  // Only round-robin transfers move the fairness pointer; reset parks it
  // on the last channel so the first search starts at channel 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_grant <= c_LAST_CH;
    end else if (w_xfer && i_mode) begin
      r_last_grant <= w_grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_xfer_count <= '0;
    end else if (w_out_hs) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign o_out_data   = r_out_data;
  assign o_out_ch     = r_out_ch;
  assign o_xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: doc/param_bus_mux.md
PARAM_BUS_MUX -- requirements
Module: param_bus_mux

Interface
REQ-001 Parameter DATA_W, default 16, width of every data channel.
REQ-002 Parameter NUM_CH, default 4, number of input channels, legal range 2..15.
REQ-003 Parameter SEL_W, default 4, width of select and out_ch; 2**SEL_W SHALL exceed NUM_CH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 mode  input  1  0 = manual select, 1 = round-robin arbitration.
REQ-007 select  input  SEL_W  manual source code; code k (1..NUM_CH) selects channel k-1.
REQ-008 in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 in_valid  input  NUM_CH  per-channel data-valid.
REQ-010 in_ready  output  NUM_CH  per-channel accept; combinational.
REQ-011 out_data  output  DATA_W  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_ch  output  SEL_W  1-based source code of the word in out_data; 0 when empty.
REQ-015 xfer_count  output  16  count of completed output handshakes.

Function
REQ-016 Output stage SHALL be one register, state EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-017 can_load SHALL be 1 when EMPTY, or when FULL and out_ready=1 in the same cycle.
REQ-018 Manual mode: grant SHALL be channel select-1 when 1<=select<=NUM_CH; select=0 or select>NUM_CH SHALL grant no channel.
REQ-019 Round-robin mode: grant SHALL go to the first channel with in_valid=1, searching from last_grant+1 upward and wrapping from NUM_CH-1 to 0; none if no in_valid set.
REQ-020 in_ready[i] SHALL equal (i is granted) AND can_load AND rstn; at most one in_ready bit SHALL be 1 in any cycle.
REQ-021 A transfer from channel i SHALL occur when in_valid[i] and in_ready[i] are both 1.
REQ-022 On transfer, the next edge SHALL load out_data=in_data[i], out_ch=i+1, out_valid=1 (latency 1 cycle).
REQ-023 On output handshake with no simultaneous transfer, the next edge SHALL set out_valid=0, out_data=0, out_ch=0.
REQ-024 Simultaneous handshake and transfer SHALL replace the word with no bubble (full throughput, 1 word/cycle).
REQ-025 FULL with out_ready=0 SHALL hold out_data, out_ch, out_valid unchanged and drive in_ready all 0.
REQ-026 last_grant SHALL update to i only on a transfer in round-robin mode; manual transfers SHALL NOT change it.
REQ-027 mode and select SHALL be evaluated every cycle; a change SHALL affect only the next transfer, never the held word.
REQ-028 xfer_count SHALL increment by 1 on each out_valid AND out_ready cycle, wrapping 16'hFFFF to 0.

Reset
REQ-029 rstn=0 at a rising edge SHALL set out_valid=0, out_data=0, out_ch=0, xfer_count=0, last_grant=NUM_CH-1.
REQ-030 While rstn=0, in_ready SHALL be all 0; a held word SHALL be discarded without counting.
REQ-031 First cycle after rstn returns to 1, round-robin SHALL favour channel 0.

Verification
REQ-032 Manual: mode=0, select=2, in_valid=4'b0010, in_data ch1=16'h00AB, out_ready=1 -> next cycle out_data=16'h00AB, out_ch=2, out_valid=1; next cycle xfer_count=1.
REQ-033 Invalid select: mode=0, select=0 then select=5 (NUM_CH=4), all in_valid=1 -> in_ready=0 throughout, out_valid=0, out_data=0.
REQ-034 Round-robin fairness: mode=1, all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence 1,2,3,4,1,2,3,4; xfer_count=8 after the last handshake.
REQ-035 Backpressure: FULL with out_ch=3, out_ready=0 for 5 cycles while in_valid=4'b1111 -> word and out_ch held, in_ready=0; out_ready=1 -> one handshake and the next word loads in the same cycle.
REQ-036 Wrap and reset: preload xfer_count to 16'hFFFF via 65535 handshakes, one more -> 0; rstn=0 mid-stream while FULL -> next cycle out_valid=0, out_ch=0, count=0, next round-robin grant channel 0.
